lcd_reader: RTL

Read-cycle controller for the character-LCD parallel bus: the read-side counterpart to the LCD write path. It generates HD44780-style read cycles (RW high, EN strobe) from a simple request interface. Status reads (RS=0) capture the busy flag and address counter; data reads (RS=1) return the DDRAM/CGRAM byte. It sits between game/control logic and the LCD pins. LCD data-bus direction and arbitration are handled outside this block; this block only samples the bus.

---
 rtl/lcd_reader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_reader.sv
// HD44780-style LCD read-cycle controller: RW/EN sequencing, byte capture, status decode.
// Optional busy-flag polling is compiled in with `define LCD_READER_POLL_EN.
module lcd_reader #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EN_HIGH = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_RECOVER = 12,
  parameter int unsigned POLL_MAX  = 255
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rd_req,
  input  logic       rd_rs,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  input  logic       poll_start,
  output logic       poll_done,
  output logic       poll_timeout,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_rs
);

  localparam int unsigned M1   = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
  localparam int unsigned M2   = (T_HOLD > T_RECOVER) ? T_HOLD : T_RECOVER;
  localparam int unsigned TMAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, RECOVER} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rs_q, rs_d;
  logic            sample;
  logic            poll_go;
  logic            poll_more;
  logic            rd_valid_q;
  logic [7:0]      rd_data_q;
  logic            busy_q;
  logic [6:0]      addr_q;
  logic            lcd_rw_q, lcd_en_q, lcd_rs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (poll_go) begin
          rs_d    = 1'b0;
          state_d = SETUP;
          cnt_d   = CW'(T_SETUP - 1);
        end else if (rd_req) begin
          rs_d    = rd_rs;
          state_d = SETUP;
          cnt_d   = CW'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = EN_HI;
          cnt_d   = CW'(T_EN_HIGH - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EN_HI: begin
        if (cnt_q == '0) begin
          sample  = 1'b1;
          state_d = HOLD;
          cnt_d   = CW'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
          cnt_d   = CW'(T_RECOVER - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          // Polling chains status reads without passing through IDLE.
          if (poll_more) begin
            rs_d    = 1'b0;
            state_d = SETUP;
            cnt_d   = CW'(T_SETUP - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      lcd_rw_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      rd_valid_q <= sample;
      if (sample) begin
        rd_data_q <= lcd_data_in;
        if (!rs_q) begin
          busy_q <= lcd_data_in[7];
          addr_q <= lcd_data_in[6:0];
        end
      end
      lcd_rw_q <= (state_d == SETUP) || (state_d == EN_HI) || (state_d == HOLD);
      lcd_en_q <= (state_d == EN_HI);
      lcd_rs_q <= rs_d && ((state_d == SETUP) || (state_d == EN_HI) || (state_d == HOLD));
    end
  end

`ifdef LCD_READER_POLL_EN
  localparam int unsigned PW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;

  logic          poll_act_q;
  logic          poll_end_q;
  logic [PW-1:0] poll_cnt_q;
  logic          poll_done_q, poll_timeout_q;
  logic          poll_last;
  logic          poll_hit;

  assign poll_go   = poll_start;
  assign poll_more = poll_act_q && !poll_end_q;
  assign poll_last = (poll_cnt_q == PW'(POLL_MAX - 1));
  assign poll_hit  = sample && poll_act_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      poll_act_q     <= 1'b0;
      poll_end_q     <= 1'b0;
      poll_cnt_q     <= '0;
      poll_done_q    <= 1'b0;
      poll_timeout_q <= 1'b0;
    end else begin
      poll_done_q    <= poll_hit && !lcd_data_in[7];
      poll_timeout_q <= poll_hit && lcd_data_in[7] && poll_last;
      if (state_q == IDLE && poll_go) begin
        poll_act_q <= 1'b1;
        poll_end_q <= 1'b0;
        poll_cnt_q <= '0;
      end else if (poll_hit) begin
        poll_cnt_q <= poll_cnt_q + PW'(1);
        if (!lcd_data_in[7] || poll_last) poll_end_q <= 1'b1;
      end else if (state_q == RECOVER && cnt_q == '0 && poll_end_q) begin
        poll_act_q <= 1'b0;
        poll_end_q <= 1'b0;
      end
    end
  end

  assign poll_done    = poll_done_q;
  assign poll_timeout = poll_timeout_q;
`else
  localparam int unsigned UNUSED_POLL_MAX = POLL_MAX;
  logic unused_poll_start;

  assign unused_poll_start = poll_start;
  assign poll_go           = 1'b0;
  assign poll_more         = 1'b0;
  assign poll_done         = 1'b0;
  assign poll_timeout      = 1'b0;
`endif

  assign rd_ready  = (state_q == IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy_flag = busy_q;
  assign addr_cnt  = addr_q;
  assign lcd_rw    = lcd_rw_q;
  assign lcd_en    = lcd_en_q;
  assign lcd_rs    = lcd_rs_q;

endmodule
